approx_mul_rr_scheduler: RTL and testbench

- Shares one combinational unsigned 8x8 approximate multiplier among NREQ requesters using round-robin arbitration.
- Registers the granted operands and drives them to the multiplier. Captures the 16-bit product one cycle later and returns it with the requester ID over a valid/ready response channel.
- The multiplier sits outside this block and connects through the mul_x / mul_y / mul_z ports. Any approximate or exact variant can be attached.
- Keeps a saturating count of completed operations for characterisation runs.

---
 rtl/approx_mul_rr_scheduler.sv | 131 +++++++++++++
 tb/tb_approx_mul_rr_scheduler.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/approx_mul_rr_scheduler.sv
// Round-robin share of one external 8x8 multiplier among NREQ requesters.
// Latency: grant edge to rsp_valid is 2 cycles; at most one op every 2 cycles.
// Backpressure: a held response (rsp_ready=0) closes the grant window, so req_ready stays 0.
module approx_mul_rr_scheduler #(
  parameter int NREQ = 4,
  parameter int IDW  = 2,
  parameter int CNTW = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [8*NREQ-1:0] req_x,
  input  logic [8*NREQ-1:0] req_y,
  output logic [7:0]        mul_x,
  output logic [7:0]        mul_y,
  input  logic [15:0]       mul_z,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [15:0]       rsp_z,
  output logic [IDW-1:0]    rsp_id,
  output logic              busy,
  output logic [CNTW-1:0]   op_count
);

  localparam int PW = $clog2(NREQ);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t        state;
  logic [PW-1:0] rr_ptr;
  logic [PW-1:0] id_reg;
  logic [PW-1:0] gnt_idx;
  logic          gnt_any;
  logic          grant_window;
  logic          rsp_hs;
  logic [7:0]    op_x;
  logic [7:0]    op_y;
  logic [7:0]    x_arr [NREQ];
  logic [7:0]    y_arr [NREQ];

  // Unpack the flat operand buses so the winner can be picked by index.
  for (genvar i = 0; i < NREQ; i++) begin : g_unpack
    assign x_arr[i] = req_x[8*i +: 8];
    assign y_arr[i] = req_y[8*i +: 8];
  end

  // A new op may start when nothing is in flight, or in the cycle the held response is taken.
  assign grant_window = (state == IDLE) || ((state == RESP) && rsp_ready);
  assign rsp_hs       = rsp_valid && rsp_ready;

  // Scan requesters starting just after the previous winner; first valid one wins.
  always_comb begin
    logic [PW-1:0] idx;
    req_ready = '0;
    gnt_any   = 1'b0;
    gnt_idx   = '0;
    idx       = '0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = PW'((int'(rr_ptr) + k) % NREQ);
      if (grant_window && !gnt_any && req_valid[idx]) begin
        gnt_any        = 1'b1;
        gnt_idx        = idx;
        req_ready[idx] = 1'b1;
      end
    end
  end

  // Control sequence plus operand capture, result capture and round-robin pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      rsp_valid <= 1'b0;
      rsp_z     <= '0;
      rsp_id    <= '0;
      op_x      <= '0;
      op_y      <= '0;
      id_reg    <= '0;
      rr_ptr    <= PW'(NREQ - 1);
    end else begin
      // Operands are sampled only on a grant; otherwise they hold to keep the multiplier quiet.
      if (gnt_any) begin
        op_x   <= x_arr[gnt_idx];
        op_y   <= y_arr[gnt_idx];
        id_reg <= gnt_idx;
        rr_ptr <= gnt_idx;
      end
      case (state)
        IDLE: begin
          if (gnt_any) begin
            state <= CALC;
          end
        end
        CALC: begin
          rsp_z     <= mul_z;
          rsp_id    <= IDW'(id_reg);
          rsp_valid <= 1'b1;
          state     <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= gnt_any ? CALC : IDLE;
          end
        end
        default: begin
          rsp_valid <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

  // Completed-response counter; sticks at all-ones instead of wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_count <= '0;
    end else if (rsp_hs && (op_count != {CNTW{1'b1}})) begin
      op_count <= op_count + 1'b1;
    end
  end

  assign mul_x = op_x;
  assign mul_y = op_y;
  assign busy  = (state != IDLE);

endmodule

// File: tb/tb_approx_mul_rr_scheduler.sv
// Scoreboard bench for approx_mul_rr_scheduler with an exact multiplier attached.
// Stimulus pushes expected {id, product} at grant time; a negedge monitor pops on each handshake.
// Response consumer is driven by the stimulus process (always ready except in the backpressure test).
module tb_approx_mul_rr_scheduler;

  localparam int NREQ = 4;
  localparam int IDW  = 2;
  localparam int CNTW = 4;
  localparam int MAXC = 15;

  logic              clk;
  logic              rst_n;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [8*NREQ-1:0] req_x;
  logic [8*NREQ-1:0] req_y;
  logic [7:0]        mul_x;
  logic [7:0]        mul_y;
  logic [15:0]       mul_z;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [15:0]       rsp_z;
  logic [IDW-1:0]    rsp_id;
  logic              busy;
  logic [CNTW-1:0]   op_count;

  typedef struct packed {
    logic [1:0]  id;
    logic [15:0] z;
  } exp_t;

  exp_t sb[$];
  int   vectors     = 0;
  int   miscompares = 0;
  int   model_cnt   = 0;

  // Per-requester operands and hand-computed exact products.
  int tx[4]    = '{200, 10, 255, 16};
  int ty[4]    = '{150, 20, 255, 16};
  int exp_z[4] = '{30000, 200, 65025, 256};
  int rr_ord[6] = '{0, 1, 2, 3, 0, 1};

  approx_mul_rr_scheduler #(
    .NREQ(NREQ),
    .IDW (IDW),
    .CNTW(CNTW)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_x    (req_x),
    .req_y    (req_y),
    .mul_x    (mul_x),
    .mul_y    (mul_y),
    .mul_z    (mul_z),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_z    (rsp_z),
    .rsp_id   (rsp_id),
    .busy     (busy),
    .op_count (op_count)
  );

  assign mul_z = {8'd0, mul_x} * {8'd0, mul_y};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0d, required %0d", nm, act, req);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input int r);
    exp_t e;
    e.id = 2'(r);
    e.z  = 16'(exp_z[r]);
    sb.push_back(e);
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    @(negedge clk);
    next_cycle();
    rst_n = 1'b1;
  endtask

  // One isolated op: grant in cycle 0, CALC in cycle 1, response in cycle 2, back to IDLE.
  task automatic single_op(input int r, input logic [3:0] mask, input string nm);
    req_valid = mask;
    @(negedge clk);
    check({nm, "_grant"}, req_ready, 32'(4'b0001 << r));
    push_exp(r);
    next_cycle();
    req_valid = '0;
    @(negedge clk);
    check({nm, "_calc_busy"}, busy, 1);
    check({nm, "_mul_x"}, mul_x, tx[r]);
    check({nm, "_mul_y"}, mul_y, ty[r]);
    check({nm, "_calc_novalid"}, rsp_valid, 0);
    next_cycle();
    @(negedge clk);
    check({nm, "_rsp_valid"}, rsp_valid, 1);
    next_cycle();
  endtask

  // Monitor: tracks a saturating completion count and checks every accepted response.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      model_cnt = 0;
    end else begin
      check("op_count", op_count, model_cnt);
      if (rsp_valid && rsp_ready) begin
        if (sb.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL rsp_unexpected: got id=%0d z=%0d, required no response", rsp_id, rsp_z);
        end else begin
          e = sb.pop_front();
          check("rsp_id", rsp_id, e.id);
          check("rsp_z", rsp_z, e.z);
        end
        if (model_cnt != MAXC) model_cnt++;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1);
  end

  initial begin
    rst_n     = 1'b0;
    req_valid = '0;
    rsp_ready = 1'b1;
    for (int i = 0; i < NREQ; i++) begin
      req_x[8*i +: 8] = 8'(tx[i]);
      req_y[8*i +: 8] = 8'(ty[i]);
    end

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_z", rsp_z, 0);
    check("rst_rsp_id", rsp_id, 0);
    check("rst_mul_x", mul_x, 0);
    check("rst_mul_y", mul_y, 0);
    check("rst_op_count", op_count, 0);
    check("rst_busy", busy, 0);
    next_cycle();
    rst_n = 1'b1;
    next_cycle();

    // Single op: 200*150 from requester 0
    single_op(0, 4'b0001, "single");
    @(negedge clk);
    check("single_cnt", op_count, 1);
    check("single_idle", busy, 0);
    next_cycle();

    // Round-robin with all requesters active, from a fresh reset
    pulse_reset();
    req_valid = 4'b1111;
    for (int g = 0; g < 6; g++) begin
      @(negedge clk);
      check("rr_grant", req_ready, 32'(4'b0001 << rr_ord[g]));
      push_exp(rr_ord[g]);
      next_cycle();
      if (g == 5) req_valid = '0;
      @(negedge clk);
      check("rr_calc_gap", req_ready, 0);
      next_cycle();
    end
    next_cycle();

    // Backpressure: pointer is 1, so requester 3 wins; then hold the response 5 cycles
    req_valid = 4'b1000;
    @(negedge clk);
    check("bp_grant", req_ready, 4'b1000);
    push_exp(3);
    next_cycle();
    req_valid = 4'b0100;
    rsp_ready = 1'b0;
    @(negedge clk);
    check("bp_calc_rdy", req_ready, 0);
    for (int i = 0; i < 5; i++) begin
      next_cycle();
      @(negedge clk);
      check("bp_valid", rsp_valid, 1);
      check("bp_z", rsp_z, 256);
      check("bp_id", rsp_id, 3);
      check("bp_rdy", req_ready, 0);
    end
    next_cycle();
    rsp_ready = 1'b1;
    @(negedge clk);
    check("bp_release_grant", req_ready, 4'b0100);
    push_exp(2);
    next_cycle();
    req_valid = '0;
    @(negedge clk);
    next_cycle();
    @(negedge clk);
    next_cycle();

    // Skip idle requesters: move pointer to 1, then only requester 0 asks
    single_op(1, 4'b0010, "pre_skip");
    single_op(0, 4'b0001, "skip_wrap");
    single_op(1, 4'b1111, "skip_ptr");

    // Reset during CALC discards the op
    req_valid = 4'b0100;
    @(negedge clk);
    check("mid_grant", req_ready, 4'b0100);
    next_cycle();
    req_valid = '0;
    #1;
    check("mid_pre_busy", busy, 1);
    check("mid_pre_mul_x", mul_x, 255);
    rst_n = 1'b0;
    #1;
    check("mid_busy", busy, 0);
    check("mid_mul_x", mul_x, 0);
    check("mid_mul_y", mul_y, 0);
    check("mid_rsp_valid", rsp_valid, 0);
    check("mid_op_count", op_count, 0);
    @(negedge clk);
    next_cycle();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("mid_no_rsp", rsp_valid, 0);
      next_cycle();
    end
    single_op(0, 4'b1111, "mid_first");

    // Saturation: 16 more ops make 17 since reset; counter must stop at 15
    for (int k = 0; k < 16; k++) begin
      single_op((k + 1) % 4, 4'b1111, "sat");
      if (k >= 13) begin
        @(negedge clk);
        check("sat_hold", op_count, 15);
        next_cycle();
      end
    end

    repeat (2) next_cycle();
    @(negedge clk);
    check("sat_final", op_count, 15);
    check("sb_drain", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
